pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Flush is OR-ed into each register's synchronous reset by the top level.
- Sequences three events: load-use bubbles (multi-cycle, counter-driven), taken-branch flushes resolved in EX, and data-memory wait states with a timeout watchdog.

---
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        if_id_flush,
    output logic        id_ex_enable,
    output logic        id_ex_flush,
    output logic        ex_mem_enable,
    output logic        mem_wb_enable,
    output logic        mem_timeout,
    output logic [1:0]  ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    localparam logic [2:0]  LU_INIT  = 3'(LOAD_LAT - 1);
    localparam logic [15:0] WAIT_MAX = 16'(MEM_TIMEOUT);

    state_t      state, next_state;
    state_t      resume_state, next_resume;
    state_t      eff_state;
    logic [2:0]  lu_cnt, lu_next;
    logic [15:0] wait_cnt, wait_next;
    logic        hazard, mem_stall;
    logic        branch_fire, bubble_fire;

    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = mem_req && !mem_ready;
    assign ctrl_state = state;

    // Leaving MEM_WAIT behaves as the interrupted state in the same cycle, so no extra latency.
    assign eff_state = (state == MEM_WAIT) ? resume_state : state;

    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_enable  = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        next_state    = state;
        next_resume   = resume_state;
        lu_next       = lu_cnt;
        branch_fire   = 1'b0;
        bubble_fire   = 1'b0;
        if (reset) begin
            next_state = RUN;
        end else if (mem_stall) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            next_state    = MEM_WAIT;
            if (state != MEM_WAIT)
                next_resume = (state == ILLEGAL) ? RUN : state;
        end else begin
            next_state = RUN;
            case (eff_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        branch_fire = 1'b1;
                    end else if (hazard) begin
                        pc_enable    = 1'b0;
                        if_id_enable = 1'b0;
                        id_ex_flush  = 1'b1;
                        bubble_fire  = 1'b1;
                        if (LOAD_LAT > 1) begin
                            next_state = LU_STALL;
                            lu_next    = LU_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    id_ex_flush  = 1'b1;
                    bubble_fire  = 1'b1;
                    if (lu_cnt <= 3'd1) begin
                        lu_next = 3'd0;
                    end else begin
                        next_state = LU_STALL;
                        lu_next    = lu_cnt - 3'd1;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_comb begin
        wait_next = 16'd0;
        if (mem_stall)
            wait_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            resume_state <= RUN;
            lu_cnt       <= 3'd0;
            wait_cnt     <= 16'd0;
            mem_timeout  <= 1'b0;
        end else begin
            state        <= next_state;
            resume_state <= next_resume;
            lu_cnt       <= lu_next;
            wait_cnt     <= wait_next;
            if (mem_stall && (wait_next == WAIT_MAX))
                mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            bubble_count <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (!pc_enable)
                stall_cycles <= stall_cycles + 32'd1;
            if (bubble_fire)
                bubble_count <= bubble_count + 32'd1;
            if (branch_fire)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench for pipeline_hazard_ctrl
// Two instances share stimulus: a is LOAD_LAT=1/MEM_TIMEOUT=8, b is LOAD_LAT=3/MEM_TIMEOUT=255.
module tb_pipeline_hazard_ctrl;

    // {pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_en}
    localparam logic [6:0] ALL_EN = 7'b1101011;
    localparam logic [6:0] BUBBLE = 7'b0001111;
    localparam logic [6:0] FREEZE = 7'b0000000;
    localparam logic [6:0] BRANCH = 7'b1111111;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

    logic       pc_en_a, ifid_en_a, ifid_fl_a, idex_en_a, idex_fl_a, exmem_en_a, memwb_en_a, tmo_a;
    logic       pc_en_b, ifid_en_b, ifid_fl_b, idex_en_b, idex_fl_b, exmem_en_b, memwb_en_b, tmo_b;
    logic [1:0] st_a, st_b;
    logic [6:0] vec_a, vec_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign vec_a = {pc_en_a, ifid_en_a, ifid_fl_a, idex_en_a, idex_fl_a, exmem_en_a, memwb_en_a};
    assign vec_b = {pc_en_b, ifid_en_b, ifid_fl_b, idex_en_b, idex_fl_b, exmem_en_b, memwb_en_b};

    pipeline_hazard_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(8)) dut_a (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_enable(pc_en_a), .if_id_enable(ifid_en_a), .if_id_flush(ifid_fl_a),
        .id_ex_enable(idex_en_a), .id_ex_flush(idex_fl_a), .ex_mem_enable(exmem_en_a),
        .mem_wb_enable(memwb_en_a), .mem_timeout(tmo_a), .ctrl_state(st_a)
    );

    pipeline_hazard_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(255)) dut_b (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_enable(pc_en_b), .if_id_enable(ifid_en_b), .if_id_flush(ifid_fl_b),
        .id_ex_enable(idex_en_b), .id_ex_flush(idex_fl_b), .ex_mem_enable(exmem_en_b),
        .mem_wb_enable(memwb_en_b), .mem_timeout(tmo_b), .ctrl_state(st_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; mem_req = 1'b1;
        #2;
        checks++; if (vec_a !== ALL_EN) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", vec_a, ALL_EN); end
        step(); step();
        checks++; if (st_a !== 2'd0 || st_b !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d/%0d exp=0", st_a, st_b); end
        checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", tmo_a); end
        reset = 1'b0; idle();
        #1;
        checks++; if (vec_b !== ALL_EN) begin errors++; $display("FAIL idle_after_reset got=%b exp=%b", vec_b, ALL_EN); end
    endtask

    task automatic test_load_use();
        load_use(5'd5);
        #1;
        checks++; if (vec_a !== BUBBLE || st_a !== 2'd0) begin errors++; $display("FAIL lat1_bubble got=%b st=%0d exp=%b st=0", vec_a, st_a, BUBBLE); end
        checks++; if (vec_b !== BUBBLE || st_b !== 2'd0) begin errors++; $display("FAIL lat3_bubble1 got=%b st=%0d exp=%b st=0", vec_b, st_b, BUBBLE); end
        step(); idle(); #1;
        checks++; if (vec_a !== ALL_EN || st_a !== 2'd0) begin errors++; $display("FAIL lat1_release got=%b st=%0d exp=%b st=0", vec_a, st_a, ALL_EN); end
        checks++; if (vec_b !== BUBBLE || st_b !== 2'd1) begin errors++; $display("FAIL lat3_bubble2 got=%b st=%0d exp=%b st=1", vec_b, st_b, BUBBLE); end
        step();
        checks++; if (vec_b !== BUBBLE || st_b !== 2'd1) begin errors++; $display("FAIL lat3_bubble3 got=%b st=%0d exp=%b st=1", vec_b, st_b, BUBBLE); end
        step();
        checks++; if (vec_b !== ALL_EN || st_b !== 2'd0) begin errors++; $display("FAIL lat3_release got=%b st=%0d exp=%b st=0", vec_b, st_b, ALL_EN); end
        load_use(5'd0); id_rs1 = 5'd0;
        #1;
        checks++; if (vec_a !== ALL_EN || vec_b !== ALL_EN) begin errors++; $display("FAIL rd_zero_no_stall got=%b/%b exp=%b", vec_a, vec_b, ALL_EN); end
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        #1;
        checks++; if (vec_a !== ALL_EN) begin errors++; $display("FAIL rs2_unused_no_stall got=%b exp=%b", vec_a, ALL_EN); end
        id_uses_rs2 = 1'b1;
        #1;
        checks++; if (vec_a !== BUBBLE) begin errors++; $display("FAIL rs2_hazard got=%b exp=%b", vec_a, BUBBLE); end
        idle();
        step();
    endtask

    task automatic test_branch();
        load_use(5'd5); ex_branch_taken = 1'b1;
        #1;
        checks++; if (vec_a !== BRANCH || vec_b !== BRANCH) begin errors++; $display("FAIL branch_flush got=%b/%b exp=%b", vec_a, vec_b, BRANCH); end
        step(); idle(); #1;
        checks++; if (st_b !== 2'd0 || vec_b !== ALL_EN) begin errors++; $display("FAIL branch_no_stall got=%b st=%0d exp=%b st=0", vec_b, st_b, ALL_EN); end
    endtask

    task automatic test_mem_wait();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (vec_a !== FREEZE || st_a !== ((i == 0) ? 2'd0 : 2'd2)) begin
                errors++; $display("FAIL mem_freeze%0d got=%b st=%0d exp=%b", i, vec_a, st_a, FREEZE);
            end
            step();
        end
        mem_ready = 1'b1;
        #1;
        checks++; if (vec_a !== ALL_EN || st_a !== 2'd2) begin errors++; $display("FAIL mem_ready_cycle got=%b st=%0d exp=%b st=2", vec_a, st_a, ALL_EN); end
        step(); idle(); #1;
        checks++; if (st_a !== 2'd0 || tmo_a !== 1'b0) begin errors++; $display("FAIL mem_resume st=%0d tmo=%b exp st=0 tmo=0", st_a, tmo_a); end
    endtask

    task automatic test_lu_mem_stall();
        load_use(5'd5);
        #1;
        checks++; if (vec_b !== BUBBLE) begin errors++; $display("FAIL lumem_b1 got=%b exp=%b", vec_b, BUBBLE); end
        step(); idle(); mem_req = 1'b1; #1;
        checks++; if (vec_b !== FREEZE || st_b !== 2'd1) begin errors++; $display("FAIL lumem_freeze1 got=%b st=%0d exp=%b st=1", vec_b, st_b, FREEZE); end
        step();
        checks++; if (vec_b !== FREEZE || st_b !== 2'd2) begin errors++; $display("FAIL lumem_freeze2 got=%b st=%0d exp=%b st=2", vec_b, st_b, FREEZE); end
        mem_ready = 1'b1; #1;
        checks++; if (vec_b !== BUBBLE) begin errors++; $display("FAIL lumem_b2 got=%b exp=%b", vec_b, BUBBLE); end
        checks++; if (vec_a !== ALL_EN) begin errors++; $display("FAIL lumem_lat1_ready got=%b exp=%b", vec_a, ALL_EN); end
        step(); idle(); #1;
        checks++; if (vec_b !== BUBBLE || st_b !== 2'd1) begin errors++; $display("FAIL lumem_b3 got=%b st=%0d exp=%b st=1", vec_b, st_b, BUBBLE); end
        step();
        checks++; if (vec_b !== ALL_EN || st_b !== 2'd0) begin errors++; $display("FAIL lumem_done got=%b st=%0d exp=%b st=0", vec_b, st_b, ALL_EN); end
    endtask

    task automatic test_timeout();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL timeout_early%0d got=%b exp=0", i, tmo_a); end
            step();
        end
        checks++; if (tmo_a !== 1'b1) begin errors++; $display("FAIL timeout_rise got=%b exp=1", tmo_a); end
        step(); step();
        checks++; if (tmo_a !== 1'b1 || vec_a !== FREEZE) begin errors++; $display("FAIL timeout_hold tmo=%b vec=%b exp tmo=1 vec=%b", tmo_a, vec_a, FREEZE); end
        checks++; if (tmo_b !== 1'b0) begin errors++; $display("FAIL timeout_b_low got=%b exp=0", tmo_b); end
        mem_ready = 1'b1; step(); mem_ready = 1'b0; step();
        checks++; if (tmo_a !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", tmo_a); end
        reset = 1'b1; #1;
        checks++; if (vec_a !== ALL_EN) begin errors++; $display("FAIL reset_midwait_outputs got=%b exp=%b", vec_a, ALL_EN); end
        step();
        checks++; if (st_a !== 2'd0 || tmo_a !== 1'b0) begin errors++; $display("FAIL reset_midwait st=%0d tmo=%b exp st=0 tmo=0", st_a, tmo_a); end
        reset = 1'b0; idle(); #1;
        checks++; if (vec_a !== ALL_EN || st_a !== 2'd0) begin errors++; $display("FAIL post_reset got=%b st=%0d exp=%b st=0", vec_a, st_a, ALL_EN); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_lu_mem_stall();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
